// File: rtl/bw_test_sequencer.sv
// Run controller for the AXI-stream bandwidth generator: launches bursts and times them.
// Optional watchdog enabled by defining BW_SEQ_TIMEOUT_EN.
module bw_test_sequencer #(
    parameter int          BEATS_W        = 32,
    parameter int          RUNS_W         = 16,
    parameter int          GAP_W          = 16,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd100_000_000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [RUNS_W-1:0]  cfg_runs,
    input  logic [BEATS_W-1:0] cfg_beats,
    input  logic [GAP_W-1:0]   cfg_gap,
    output logic               gen_start,
    output logic [BEATS_W-1:0] gen_beats,
    output logic               gen_abort,
    input  logic               gen_done,
    output logic               busy,
    output logic               seq_done,
    output logic               err_cfg,
    output logic               aborted,
    output logic               timed_out,
    output logic [RUNS_W-1:0]  run_count,
    output logic [63:0]        last_cycles,
    output logic [63:0]        min_cycles,
    output logic [63:0]        max_cycles,
    output logic [63:0]        sum_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } state_t;

    state_t             state;
    logic [63:0]        cycle_cnt;
    logic [63:0]        start_ts;
    logic [RUNS_W-1:0]  runs_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;

    logic [63:0]        elapsed;
    logic [64:0]        sum_ext;
    logic [63:0]        sum_sat;
    logic [RUNS_W-1:0]  run_next;
    logic               cfg_ok;
    logic               abort_req;

    // Modulo-2^64 subtraction keeps durations correct across counter wrap.
    assign elapsed   = cycle_cnt - start_ts;
    assign sum_ext   = {1'b0, sum_cycles} + {1'b0, elapsed};
    assign sum_sat   = sum_ext[64] ? {64{1'b1}} : sum_ext[63:0];
    assign run_next  = run_count + RUNS_W'(1);
    assign cfg_ok    = (cfg_runs != '0) && (cfg_beats != '0);
    assign abort_req = cfg_abort && (state != IDLE);

`ifdef BW_SEQ_TIMEOUT_EN
    logic wd_hit;
    assign wd_hit = (elapsed >= TIMEOUT_CYCLES - 64'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            start_ts    <= '0;
            runs_q      <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            gen_start   <= 1'b0;
            gen_beats   <= '0;
            gen_abort   <= 1'b0;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
            err_cfg     <= 1'b0;
            aborted     <= 1'b0;
`ifdef BW_SEQ_TIMEOUT_EN
            timed_out   <= 1'b0;
`endif
            run_count   <= '0;
            last_cycles <= '0;
            min_cycles  <= '1;
            max_cycles  <= '0;
            sum_cycles  <= '0;
        end else begin
            gen_start <= 1'b0;
            gen_abort <= 1'b0;
            seq_done  <= 1'b0;
            if (abort_req) begin
                // Abort beats a coincident gen_done; that run is dropped.
                gen_abort <= 1'b1;
                aborted   <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cfg_start) begin
                            if (cfg_ok) begin
                                runs_q      <= cfg_runs;
                                gap_q       <= cfg_gap;
                                gen_beats   <= cfg_beats;
                                run_count   <= '0;
                                last_cycles <= '0;
                                min_cycles  <= '1;
                                max_cycles  <= '0;
                                sum_cycles  <= '0;
                                err_cfg     <= 1'b0;
                                aborted     <= 1'b0;
`ifdef BW_SEQ_TIMEOUT_EN
                                timed_out   <= 1'b0;
`endif
                                gen_start   <= 1'b1;
                                busy        <= 1'b1;
                                state       <= LAUNCH;
                            end else begin
                                err_cfg <= 1'b1;
                            end
                        end
                    end
                    LAUNCH: begin
                        start_ts <= cycle_cnt;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (gen_done) begin
                            last_cycles <= elapsed;
                            sum_cycles  <= sum_sat;
                            run_count   <= run_next;
                            if (elapsed < min_cycles) begin
                                min_cycles <= elapsed;
                            end
                            if (elapsed > max_cycles) begin
                                max_cycles <= elapsed;
                            end
                            if (run_next == runs_q) begin
                                seq_done <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                gap_cnt <= gap_q;
                                state   <= GAP;
                            end
`ifdef BW_SEQ_TIMEOUT_EN
                        end else if (wd_hit) begin
                            gen_abort <= 1'b1;
                            timed_out <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
`endif
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            gen_start <= 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bw_test_sequencer.sv
// Directed bench for bw_test_sequencer with a queue-based statistics scoreboard.
// Timeout case is exercised only when BW_SEQ_TIMEOUT_EN is defined.
module tb_bw_test_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_runs = '0;
    logic [31:0] cfg_beats = '0;
    logic [15:0] cfg_gap = '0;
    logic        gen_done = 1'b0;
    logic        gen_start;
    logic [31:0] gen_beats;
    logic        gen_abort;
    logic        busy;
    logic        seq_done;
    logic        err_cfg;
    logic        aborted;
    logic        timed_out;
    logic [15:0] run_count;
    logic [63:0] last_cycles;
    logic [63:0] min_cycles;
    logic [63:0] max_cycles;
    logic [63:0] sum_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] rc;
        logic [63:0] last;
        logic [63:0] mn;
        logic [63:0] mx;
        logic [63:0] sum;
    } exp_t;

    exp_t sb[$];

    bw_test_sequencer #(
`ifdef BW_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES(64'd50)
`else
        .TIMEOUT_CYCLES(64'd100_000_000)
`endif
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .cfg_start(cfg_start),
        .cfg_abort(cfg_abort),
        .cfg_runs(cfg_runs),
        .cfg_beats(cfg_beats),
        .cfg_gap(cfg_gap),
        .gen_start(gen_start),
        .gen_beats(gen_beats),
        .gen_abort(gen_abort),
        .gen_done(gen_done),
        .busy(busy),
        .seq_done(seq_done),
        .err_cfg(err_cfg),
        .aborted(aborted),
        .timed_out(timed_out),
        .run_count(run_count),
        .last_cycles(last_cycles),
        .min_cycles(min_cycles),
        .max_cycles(max_cycles),
        .sum_cycles(sum_cycles)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected statistics after the first n runs of the given durations.
    function automatic exp_t model(input int n, input int d0,
                                   input int d1 = 0, input int d2 = 0);
        int   d[3];
        exp_t e;
        d = '{d0, d1, d2};
        e.rc = 16'(n);
        e.mn = '1;
        e.mx = '0;
        e.sum = '0;
        e.last = '0;
        for (int i = 0; i < n; i++) begin
            e.last = 64'(d[i]);
            e.sum += 64'(d[i]);
            if (64'(d[i]) < e.mn) e.mn = 64'(d[i]);
            if (64'(d[i]) > e.mx) e.mx = 64'(d[i]);
        end
        return e;
    endfunction

    task automatic check_stats(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_run_count"}, 64'(run_count), 64'(e.rc));
            chk({tag, "_last"}, last_cycles, e.last);
            chk({tag, "_min"}, min_cycles, e.mn);
            chk({tag, "_max"}, max_cycles, e.mx);
            chk({tag, "_sum"}, sum_cycles, e.sum);
        end
    endtask

    task automatic start_seq(input int r, input int b, input int g);
        cfg_runs  = 16'(r);
        cfg_beats = 32'(b);
        cfg_gap   = 16'(g);
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
    endtask

    task automatic wait_start(input int exp_n, input string tag);
        int n = 0;
        while (gen_start !== 1'b1 && n < 500) begin
            tick;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    // Called in the gen_start cycle; raises gen_done dur cycles later.
    task automatic burst(input int dur, input bit poke, input bit abrt);
        if (poke) begin
            cfg_start = 1'b1;
            cfg_runs  = 16'd0;
            cfg_beats = 32'd99;
        end
        tick;
        cfg_start = 1'b0;
        repeat (dur - 1) tick;
        gen_done  = 1'b1;
        cfg_abort = abrt;
        tick;
        gen_done  = 1'b0;
        cfg_abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;

        repeat (3) tick;
        chk("rst_gen_start", 64'(gen_start), 64'd0);
        chk("rst_gen_abort", 64'(gen_abort), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq_done", 64'(seq_done), 64'd0);
        chk("rst_err_cfg", 64'(err_cfg), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_timed_out", 64'(timed_out), 64'd0);
        chk("rst_gen_beats", 64'(gen_beats), 64'd0);
        sb.push_back(model(0, 0));
        check_stats("rst");
        resetn = 1'b1;
        tick;

        sb.push_back(model(1, 20));
        start_seq(1, 16, 0);
        wait_start(0, "t1_launch_delay");
        chk("t1_gen_beats", 64'(gen_beats), 64'd16);
        chk("t1_busy", 64'(busy), 64'd1);
        burst(20, 0, 0);
        chk("t1_seq_done", 64'(seq_done), 64'd1);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        check_stats("t1");
        tick;
        chk("t1_seq_done_pulse", 64'(seq_done), 64'd0);
        gen_done = 1'b1;
        tick;
        gen_done = 1'b0;
        tick;
        chk("t1_stray_done_rc", 64'(run_count), 64'd1);
        chk("t1_stray_done_busy", 64'(busy), 64'd0);

        sb.push_back(model(3, 10, 30, 20));
        start_seq(3, 40, 5);
        wait_start(0, "t2_launch_delay");
        burst(10, 0, 0);
        chk("t2_mid_busy", 64'(busy), 64'd1);
        chk("t2_mid_seq_done", 64'(seq_done), 64'd0);
        wait_start(6, "t2_gap1");
        burst(30, 0, 0);
        wait_start(6, "t2_gap2");
        burst(20, 0, 0);
        chk("t2_seq_done", 64'(seq_done), 64'd1);
        check_stats("t2");
        tick;

        start_seq(0, 16, 2);
        chk("t3_err_cfg", 64'(err_cfg), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (10) begin
            if (gen_start === 1'b1) seen++;
            tick;
        end
        chk("t3_no_launch", 64'(seen), 64'd0);
        sb.push_back(model(1, 5));
        start_seq(1, 8, 3);
        chk("t3_err_cleared", 64'(err_cfg), 64'd0);
        wait_start(0, "t3_launch_delay");
        burst(5, 1, 0);
        chk("t3_beats_kept", 64'(gen_beats), 64'd8);
        chk("t3_busy_start_ignored", 64'(err_cfg), 64'd0);
        chk("t3_seq_done", 64'(seq_done), 64'd1);
        check_stats("t3");
        tick;

        sb.push_back(model(1, 12));
        start_seq(4, 4, 2);
        wait_start(0, "t4_launch_delay");
        burst(12, 0, 0);
        wait_start(3, "t4_gap1");
        burst(15, 0, 1);
        chk("t4_gen_abort", 64'(gen_abort), 64'd1);
        chk("t4_aborted", 64'(aborted), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_no_seq_done", 64'(seq_done), 64'd0);
        check_stats("t4");
        tick;
        chk("t4_gen_abort_pulse", 64'(gen_abort), 64'd0);
        seen = 0;
        repeat (8) begin
            if (gen_start === 1'b1 || seq_done === 1'b1) seen++;
            tick;
        end
        chk("t4_stays_idle", 64'(seen), 64'd0);

        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        chk("t5_idle_abort_pulse", 64'(gen_abort), 64'd0);
        chk("t5_idle_abort_busy", 64'(busy), 64'd0);
        tick;
        chk("t5_idle_abort_pulse2", 64'(gen_abort), 64'd0);

        @(negedge clock);
        force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFB;
        @(posedge clock);
        #1;
        release dut.cycle_cnt;
        sb.push_back(model(1, 10));
        start_seq(1, 32, 0);
        chk("t6_aborted_cleared", 64'(aborted), 64'd0);
        wait_start(0, "t6_launch_delay");
        burst(10, 0, 0);
        chk("t6_seq_done", 64'(seq_done), 64'd1);
        check_stats("t6");
        tick;

`ifdef BW_SEQ_TIMEOUT_EN
        start_seq(1, 4, 0);
        wait_start(0, "t7_launch_delay");
        n = 0;
        while (gen_abort !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        chk("t7_abort_delay", 64'(n), 64'd50);
        chk("t7_timed_out", 64'(timed_out), 64'd1);
        chk("t7_run_count", 64'(run_count), 64'd0);
        chk("t7_seq_done", 64'(seq_done), 64'd0);
        tick;
`else
        n = 0;
        chk("t7_timed_out_tied", 64'(timed_out), 64'(n));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
